// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: three-stage fixed-point RGB-to-luma converter with per-frame pixel counting
module rgb2gray_pipe #(
  parameter int WIDTH        = 8,
  parameter int CW           = 9,
  parameter int KR           = 77,
  parameter int KG           = 150,
  parameter int KB           = 29,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r_data_in,
  input  logic [WIDTH-1:0] g_data_in,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic             data_in_done,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_done,
  output logic             frame_done,
  output logic [CNT_W-1:0] pixel_count
);
  localparam int PW = WIDTH + CW;
  localparam int SW = PW + 2;
  localparam logic [SW-1:0] MAXV = SW'((1 << WIDTH) - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_PIXELS - 1);
  logic [PW-1:0] pr, pg, pb;
  logic [SW-1:0] s, y;
  logic v1, v2;
  assign y = s >> 8;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pr            <= '0;
      pg            <= '0;
      pb            <= '0;
      s             <= '0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      data_out      <= '0;
      data_out_done <= 1'b0;
      frame_done    <= 1'b0;
      pixel_count   <= '0;
    end else begin
      v1            <= data_in_done;
      v2            <= v1;
      data_out_done <= v2;
      frame_done    <= v2 && (pixel_count == LAST);
      if (data_in_done) begin
        pr <= PW'(r_data_in) * PW'(KR);
        pg <= PW'(g_data_in) * PW'(KG);
        pb <= PW'(b_data_in) * PW'(KB);
      end
      if (v1) s <= SW'(pr) + SW'(pg) + SW'(pb) + SW'(128);
      if (v2) begin
        data_out    <= (y > MAXV) ? '1 : y[WIDTH-1:0];
        pixel_count <= (pixel_count == LAST) ? '0 : pixel_count + 1'b1;
      end
    end
endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: directed checks of gray conversion, bubbles, frame wrap, saturation and reset
module tb_rgb2gray_pipe;
  logic clk = 0, reset = 1;
  logic [7:0] r = 0, g = 0, b = 0;
  logic vin = 0;
  logic [7:0] dout, dout_s, dout_1;
  logic done, done_s, done_1, fd, fd_s, fd_1;
  logic [1:0] pc, pc_s;
  logic [0:0] pc_1;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  rgb2gray_pipe #(.FRAME_PIXELS(4)) dut (
    .clk(clk), .reset(reset), .r_data_in(r), .g_data_in(g), .b_data_in(b),
    .data_in_done(vin), .data_out(dout), .data_out_done(done),
    .frame_done(fd), .pixel_count(pc));

  rgb2gray_pipe #(.KR(128), .KG(128), .KB(128), .FRAME_PIXELS(4)) dut_sat (
    .clk(clk), .reset(reset), .r_data_in(r), .g_data_in(g), .b_data_in(b),
    .data_in_done(vin), .data_out(dout_s), .data_out_done(done_s),
    .frame_done(fd_s), .pixel_count(pc_s));

  rgb2gray_pipe #(.FRAME_PIXELS(1)) dut_one (
    .clk(clk), .reset(reset), .r_data_in(r), .g_data_in(g), .b_data_in(b),
    .data_in_done(vin), .data_out(dout_1), .data_out_done(done_1),
    .frame_done(fd_1), .pixel_count(pc_1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] rr, gg, bb, input logic v);
    r = rr; g = gg; b = bb; vin = v;
    @(posedge clk); #1;
  endtask

  task automatic out(input string tag, input logic d, input logic [7:0] y,
                     input logic f, input logic [1:0] p);
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".data"}, 32'(dout), 32'(y));
    chk({tag, ".frame"}, 32'(fd), 32'(f));
    chk({tag, ".count"}, 32'(pc), 32'(p));
  endtask

  initial begin
    logic [1:0] exp_pc [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset = 0;
    out("reset_state", 0, 0, 0, 0);
    // four back-to-back pixels, first output after the third edge
    step(255, 0, 0, 1);
    step(0, 255, 0, 1);
    chk("lat_early", 32'(done), 0);
    step(0, 0, 255, 1);
    out("red", 1, 77, 0, 1);
    step(255, 255, 255, 1);
    out("green", 1, 149, 0, 2);
    step(0, 0, 0, 0);
    out("blue", 1, 29, 0, 3);
    step(0, 0, 0, 0);
    out("white", 1, 255, 1, 0);
    chk("sat_data", 32'(dout_s), 255);
    chk("one_frame", 32'(fd_1), 1);
    chk("one_count", 32'(pc_1), 0);
    step(0, 0, 0, 0);
    out("idle_hold", 0, 255, 0, 0);
    chk("one_frame_idle", 32'(fd_1), 0);
    // bubble pattern 1,0,1,1,0
    step(10, 10, 10, 1);
    step(200, 200, 200, 0);
    step(20, 20, 20, 1);
    out("bub0", 1, 10, 0, 1);
    step(30, 30, 30, 1);
    out("bub1", 0, 10, 0, 1);
    step(0, 0, 0, 0);
    out("bub2", 1, 20, 0, 2);
    step(0, 0, 0, 0);
    out("bub3", 1, 30, 0, 3);
    step(0, 0, 0, 0);
    out("bub4", 0, 30, 0, 3);
    // two pixels in flight, then asynchronous reset mid-cycle
    step(50, 50, 50, 1);
    step(60, 60, 60, 1);
    vin = 0;
    #3 reset = 1;
    #1 out("async_reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("no_ghost", 32'(done), 0);
    end
    // six-pixel stream across a 4-pixel frame boundary
    for (int i = 0; i < 8; i++) begin
      if (i < 6) step(8'(i + 1), 8'(i + 1), 8'(i + 1), 1);
      else step(0, 0, 0, 0);
      if (i == 1) chk("restart_lat", 32'(done), 0);
      if (i >= 2) out("wrap", 1, 8'(i - 1), (i == 5), exp_pc[i-2]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
